roba_mul_pipe: RTL and testbench
================================

// Module: roba_mul_pipe
// PURPOSE
//  Parametrised, pipelined signed approximate multiplier with a selectable mode:
//  exact, single-term ROBA, or two-term ROBA (the ROBA product plus a ROBA
//  estimate of the residual product). It takes a valid/ready stream of operand
//  pairs with tags and returns 2*W-bit signed products after a fixed 3-cycle
//  latency, with full backpressure. It is the datapath-facing successor of the
//  combinational 32-bit down-rounding ROBA multiplier.
// PARAMETERS
//  W      32  operand width, signed two's complement, 4..64
//  TAG_W  4   width of the user tag carried alongside each operation
//  LOG_W  $clog2(W)  derived; leading-one encoder output width; do not override
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        operand pair present
//  in_ready   out  1        block accepts operand pair this cycle
//  in_x       in   W        signed multiplicand
//  in_y       in   W        signed multiplier
//  in_mode    in   2        00 exact, 01 ROBA, 10 ROBA+correction, 11 exact
//  in_tag     in   TAG_W    opaque tag, returned unchanged
//  out_valid  out  1        result present
//  out_ready  in   1        consumer accepts result
//  out_p      out  2W       signed product
//  out_tag    out  TAG_W    tag of this result
//  out_mode   out  2        mode the result was computed in
//  op_count   out  32       number of accepted ops; wraps at 2^32
// BEHAVIOUR
//  Reset: out_valid=0, out_p=0, out_tag=0, out_mode=0, op_count=0, all stage
//   valid bits=0. in_ready=1 from the first cycle after reset deasserts.
//  Handshake: transfer on valid&ready. Inputs are sampled only on transfer.
//   out_* hold stable while out_valid=1 and out_ready=0.
//  Pipeline: S1 register -> S2 register -> S3 (output) register. Latency is 3
//   cycles from the input transfer to out_valid. Stage k advances when stage k+1
//   is empty or advancing. in_ready = !s1_valid | s1_advance. Throughput is 1/clk.
//  S1: |x| and |y| as W-bit unsigned (-2^(W-1) -> 2^(W-1), no overflow);
//   sign = x[W-1]^y[W-1]; latch mode and tag.
//  S2: R(a) = 2^floor(log2 a), with a leading-one encoder giving e(a).
//   T(a,b) = (R(a)*b) + (R(b)*a) - R(a)*R(b), computed using shifts only.
//   Mode 01: M = T(|x|,|y|). Mode 10: M = T(|x|,|y|) + T(|x|-R|x|, |y|-R|y|).
//   Modes 00/11: M = |x|*|y| exact. M is 2W bits unsigned.
//  S3: out_p = sign ? -M : M.
//  Zero: if either operand is 0, M=0 in every mode and out_p=0 with no negative
//   zero. A residual of 0 makes its correction term 0.
//  op_count increments on each input transfer, including in the cycle that also
//   produces an output.
//  Mode changes between back-to-back ops take effect per op; there is no flush.
//  Reset mid-operation: all in-flight ops are discarded and no partial result
//   is presented.
// STRUCTURE
//  Package roba_mul_pkg: mode_e enum (MODE_EXACT, MODE_ROBA, MODE_ROBA2,
//   MODE_RSVD), function lzenc(), and localparam defaults.
//  Sub-module roba_term #(W): combinational unit taking a and b. It outputs T(a,b)
//   and R(a), R(b). It is instantiated twice in S2: main term and correction term.
//  The exact product uses a plain '*' in S2. Top level holds stage registers,
//   handshake and op_count.
// TESTING (W=32)
//  1 Mode 01, x=3, y=3 -> out_p=8. Mode 10, same operands -> out_p=9.
//  2 Mode 01, x=-5, y=6 -> out_p=-28. Mode 10 -> -30. Mode 00 -> -30.
//  3 Mode 10, x=13, y=11 -> out_p=142. Mode 01 -> 128. Mode 00 -> 143.
//  4 x=-2^31, y=-1, mode 00 -> out_p=2^31, positive. x=0, y=-7, any mode -> 0.
//  5 Stream 8 ops with out_ready low for cycles 4-9: no loss or duplication,
//   in-order tags, in_ready drops once 3 ops are held, and op_count=8.
//  6 Assert rst with 2 ops in flight: out_valid=0 and op_count=0 while rst is
//   high. After release, a new op x=2, y=2, mode 01 returns 4 after 3 cycles.

Source files
------------

// File: rtl/roba_mul_pkg.sv
// Shared types and helpers for the pipelined ROBA approximate multiplier.
package roba_mul_pkg;

    localparam int DEF_W     = 32;
    localparam int DEF_TAG_W = 4;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'b00,
        MODE_ROBA  = 2'b01,
        MODE_ROBA2 = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    // Position of the most significant set bit; 0 for a zero input.
    function automatic logic [6:0] lzenc(input logic [63:0] v);
        logic [6:0] e;
        e = 7'd0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) begin
                e = 7'(i);
            end
        end
        return e;
    endfunction

endpackage

// File: rtl/roba_mul_pipe_term.sv
// Combinational ROBA term T(a,b) = R(a)*b + R(b)*a - R(a)*R(b), built from shifts.
module roba_term
    import roba_mul_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int LOG_W = $clog2(W)
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] t,
    output logic [W-1:0]   ra,
    output logic [W-1:0]   rb
);

    localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};

    logic [LOG_W-1:0] w_ea;
    logic [LOG_W-1:0] w_eb;
    logic [LOG_W:0]   w_esum;
    logic             w_a_nz;
    logic             w_b_nz;
    logic [2*W-1:0]   w_b_sh;
    logic [2*W-1:0]   w_a_sh;
    logic [2*W-1:0]   w_rr;

    assign w_a_nz = |a;
    assign w_b_nz = |b;
    assign w_ea   = LOG_W'(lzenc(64'(a)));
    assign w_eb   = LOG_W'(lzenc(64'(b)));
    assign w_esum = {1'b0, w_ea} + {1'b0, w_eb};

    assign ra = w_a_nz ? (ONE_W << w_ea) : {W{1'b0}};
    assign rb = w_b_nz ? (ONE_W << w_eb) : {W{1'b0}};

    // The encoder reports 0 for a zero operand, so each shift term is gated on a nonzero source.
    assign w_b_sh = w_a_nz ? ({{W{1'b0}}, b} << w_ea) : {(2*W){1'b0}};
    assign w_a_sh = w_b_nz ? ({{W{1'b0}}, a} << w_eb) : {(2*W){1'b0}};
    assign w_rr   = (w_a_nz & w_b_nz) ? (ONE_2W << w_esum) : {(2*W){1'b0}};

    assign t = w_b_sh + w_a_sh - w_rr;

endmodule

// File: rtl/roba_mul_pipe.sv
// Three-stage signed multiplier (exact / ROBA / ROBA with residual correction)
// with valid/ready handshake, tag passthrough and an accepted-op counter.
module roba_mul_pipe
    import roba_mul_pkg::*;
#(
    parameter  int W     = DEF_W,
    parameter  int TAG_W = DEF_TAG_W,
    localparam int LOG_W = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_p,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_mode,
    output logic [31:0]      op_count
);

    localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};

    logic             r_s1_valid;
    logic [W-1:0]     r_s1_ax;
    logic [W-1:0]     r_s1_ay;
    logic             r_s1_sign;
    logic [1:0]       r_s1_mode;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic [2*W-1:0]   r_s2_m;
    logic             r_s2_sign;
    logic [1:0]       r_s2_mode;
    logic [TAG_W-1:0] r_s2_tag;

    logic             r_out_valid;
    logic [2*W-1:0]   r_out_p;
    logic [TAG_W-1:0] r_out_tag;
    logic [1:0]       r_out_mode;
    logic [31:0]      r_op_count;

    logic             w_s3_free;
    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_in_fire;
    logic [W-1:0]     w_ax;
    logic [W-1:0]     w_ay;
    logic [2*W-1:0]   w_t_main;
    logic [2*W-1:0]   w_t_corr;
    logic [2*W-1:0]   w_corr;
    logic [W-1:0]     w_rx;
    logic [W-1:0]     w_ry;
    logic [W-1:0]     w_res_x;
    logic [W-1:0]     w_res_y;
    logic [W-1:0]     w_corr_rx;
    logic [W-1:0]     w_corr_ry;
    logic [2*W-1:0]   w_exact;
    logic [2*W-1:0]   w_m;
    logic [2*W-1:0]   w_p;

    assign w_s3_free = ~r_out_valid | out_ready;
    assign w_s2_adv  = r_s2_valid & w_s3_free;
    assign w_s1_adv  = r_s1_valid & (~r_s2_valid | w_s2_adv);
    assign in_ready  = ~r_s1_valid | w_s1_adv;
    assign w_in_fire = in_valid & in_ready;

    // Magnitudes as unsigned W bits: the most negative value maps to 2^(W-1) cleanly.
    assign w_ax = in_x[W-1] ? (~in_x + ONE_W) : in_x;
    assign w_ay = in_y[W-1] ? (~in_y + ONE_W) : in_y;

    roba_term #(.W(W), .LOG_W(LOG_W)) u_term_main (
        .a  (r_s1_ax),
        .b  (r_s1_ay),
        .t  (w_t_main),
        .ra (w_rx),
        .rb (w_ry)
    );

    assign w_res_x = r_s1_ax - w_rx;
    assign w_res_y = r_s1_ay - w_ry;

    roba_term #(.W(W), .LOG_W(LOG_W)) u_term_corr (
        .a  (w_res_x),
        .b  (w_res_y),
        .t  (w_t_corr),
        .ra (w_corr_rx),
        .rb (w_corr_ry)
    );

    assign w_corr  = ((|w_corr_rx) & (|w_corr_ry)) ? w_t_corr : {(2*W){1'b0}};
    assign w_exact = {{W{1'b0}}, r_s1_ax} * {{W{1'b0}}, r_s1_ay};

    // Stage-2 magnitude selection by the op's own mode.
    always_comb begin
        w_m = {(2*W){1'b0}};
        case (mode_e'(r_s1_mode))
            MODE_ROBA:  w_m = w_t_main;
            MODE_ROBA2: w_m = w_t_main + w_corr;
            MODE_EXACT: w_m = w_exact;
            MODE_RSVD:  w_m = w_exact;
            default:    w_m = w_exact;
        endcase
    end

    assign w_p = r_s2_sign ? (~r_s2_m + ONE_2W) : r_s2_m;

    // Stage valid bits and the accepted-op counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_op_count  <= 32'd0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (~r_s2_valid | w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s3_free) begin
                r_out_valid <= r_s2_valid;
            end
            if (w_in_fire) begin
                r_op_count <= r_op_count + 32'd1;
            end
        end
    end

    // Stage payloads load only when their stage takes a new op, so held data stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_ax    <= {W{1'b0}};
            r_s1_ay    <= {W{1'b0}};
            r_s1_sign  <= 1'b0;
            r_s1_mode  <= 2'b00;
            r_s1_tag   <= {TAG_W{1'b0}};
            r_s2_m     <= {(2*W){1'b0}};
            r_s2_sign  <= 1'b0;
            r_s2_mode  <= 2'b00;
            r_s2_tag   <= {TAG_W{1'b0}};
            r_out_p    <= {(2*W){1'b0}};
            r_out_tag  <= {TAG_W{1'b0}};
            r_out_mode <= 2'b00;
        end else begin
            if (w_in_fire) begin
                r_s1_ax   <= w_ax;
                r_s1_ay   <= w_ay;
                r_s1_sign <= in_x[W-1] ^ in_y[W-1];
                r_s1_mode <= in_mode;
                r_s1_tag  <= in_tag;
            end
            if (w_s1_adv) begin
                r_s2_m    <= w_m;
                r_s2_sign <= r_s1_sign;
                r_s2_mode <= r_s1_mode;
                r_s2_tag  <= r_s1_tag;
            end
            if (w_s2_adv) begin
                r_out_p    <= w_p;
                r_out_tag  <= r_s2_tag;
                r_out_mode <= r_s2_mode;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;
    assign out_tag   = r_out_tag;
    assign out_mode  = r_out_mode;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_roba_mul_pipe.sv
// Self-checking bench for roba_mul_pipe (W=32): arithmetic model + scoreboard,
// directed vectors with literal expectations, backpressure and reset-in-flight.
module tb_roba_mul_pipe;

    localparam int W     = 32;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_x;
    logic [W-1:0]     in_y;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_p;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       out_mode;
    logic [31:0]      op_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint     p;
        logic [3:0] tag;
        logic [1:0] mode;
    } exp_t;

    exp_t sb[$];
    int   n_out      = 0;
    bit   track_full = 1'b0;

    roba_mul_pipe #(.W(W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag),
        .out_mode  (out_mode),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    // Largest power of two not above a (0 for a == 0).
    function automatic longint r_of(longint a);
        longint r;
        if (a == 0) return 0;
        r = 1;
        while (r * 2 <= a) r = r * 2;
        return r;
    endfunction

    function automatic longint t_of(longint a, longint b);
        return r_of(a) * b + r_of(b) * a - r_of(a) * r_of(b);
    endfunction

    function automatic longint model(longint x, longint y, logic [1:0] mode);
        longint ax, ay, m;
        ax = (x < 0) ? -x : x;
        ay = (y < 0) ? -y : y;
        case (mode)
            2'b01:   m = t_of(ax, ay);
            2'b10:   m = t_of(ax, ay) + t_of(ax - r_of(ax), ay - r_of(ay));
            default: m = ax * ay;
        endcase
        return ((x < 0) != (y < 0)) ? -m : m;
    endfunction

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: samples mid-cycle, when handshakes for the next edge are settled.
    initial begin
        exp_t           e;
        bit             prev_hold;
        logic [2*W-1:0] prev_p;
        logic [3:0]     prev_tag;
        logic [1:0]     prev_mode;
        prev_hold = 1'b0;
        prev_p    = '0;
        prev_tag  = '0;
        prev_mode = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", longint'(out_valid), 1);
                    check("hold_p", $signed(out_p), $signed(prev_p));
                    check("hold_tag", longint'(out_tag), longint'(prev_tag));
                    check("hold_mode", longint'(out_mode), longint'(prev_mode));
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_out actual tag=%0d required no output", out_tag);
                    end else begin
                        e = sb.pop_front();
                        check("model_p", $signed(out_p), e.p);
                        check("model_tag", longint'(out_tag), longint'(e.tag));
                        check("model_mode", longint'(out_mode), longint'(e.mode));
                    end
                end
                if (in_valid && in_ready) begin
                    e.p    = model(longint'($signed(in_x)), longint'($signed(in_y)), in_mode);
                    e.tag  = in_tag;
                    e.mode = in_mode;
                    sb.push_back(e);
                end
                if (track_full && in_valid && !in_ready) begin
                    check("full_depth", sb.size(), 3);
                end
                prev_hold = out_valid && !out_ready;
                prev_p    = out_p;
                prev_tag  = out_tag;
                prev_mode = out_mode;
            end
        end
    end

    task automatic do_op(int x, int y, logic [1:0] mode, logic [3:0] tag, longint exp, string name);
        int n;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_x      = x;
        in_y      = y;
        in_mode   = mode;
        in_tag    = tag;
        out_ready = 1'b1;
        @(negedge clk);
        check({name, "_in_ready"}, longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check({name, "_latency"}, n, 3);
        check({name, "_p"}, $signed(out_p), exp);
        check({name, "_tag"}, longint'(out_tag), longint'(tag));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  sent;
        int  spurious;
        bit  saw_low;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_mode   = 2'b00;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_p", $signed(out_p), 0);
        check("rst_out_tag", longint'(out_tag), 0);
        check("rst_out_mode", longint'(out_mode), 0);
        check("rst_op_count", longint'(op_count), 0);
        check("rst_in_ready", longint'(in_ready), 1);

        // Pin the model to hand-computed values
        check("pin_3x3_roba", model(3, 3, 2'b01), 8);
        check("pin_13x11_roba2", model(13, 11, 2'b10), 142);
        check("pin_m5x6_roba", model(-5, 6, 2'b01), -28);

        // Directed vectors with literal expectations
        do_op(3, 3, 2'b01, 4'd1, 8, "v3x3_roba");
        do_op(3, 3, 2'b10, 4'd2, 9, "v3x3_roba2");
        do_op(-5, 6, 2'b01, 4'd3, -28, "vm5x6_roba");
        do_op(-5, 6, 2'b10, 4'd4, -30, "vm5x6_roba2");
        do_op(-5, 6, 2'b00, 4'd5, -30, "vm5x6_exact");
        do_op(13, 11, 2'b10, 4'd6, 142, "v13x11_roba2");
        do_op(13, 11, 2'b01, 4'd7, 128, "v13x11_roba");
        do_op(13, 11, 2'b00, 4'd8, 143, "v13x11_exact");
        do_op(int'(32'h8000_0000), -1, 2'b00, 4'd9, 64'sd2147483648, "vmin_x_m1");
        do_op(0, -7, 2'b00, 4'd10, 0, "vzero_exact");
        do_op(0, -7, 2'b01, 4'd11, 0, "vzero_roba");
        do_op(0, -7, 2'b10, 4'd12, 0, "vzero_roba2");
        do_op(0, -7, 2'b11, 4'd13, 0, "vzero_rsvd");
        do_op(int'(32'h8000_0000), int'(32'h8000_0000), 2'b01, 4'd14, 64'sd4611686018427387904, "vmin_sq_roba");
        do_op(-12, -12, 2'b11, 4'd15, 144, "vm12_rsvd");
        do_op(7, -1, 2'b10, 4'd0, -7, "v7xm1_roba2");
        check("op_count_directed", longint'(op_count), 16);

        // Backpressure stream: 8 ops, consumer stalled for cycles 4..9
        pulse_reset();
        n_out      = 0;
        sent       = 0;
        saw_low    = 1'b0;
        track_full = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 4 && cyc <= 9);
            in_valid  = (sent < 8);
            in_x      = sent * 7 - 9;
            in_y      = 5 - sent * 3;
            in_mode   = 2'(sent % 4);
            in_tag    = 4'(sent);
            @(negedge clk);
            if (in_valid && !in_ready) saw_low = 1'b1;
            if (in_valid && in_ready) sent++;
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        track_full = 1'b0;
        @(negedge clk);
        check("stream_sent", sent, 8);
        check("stream_outputs", n_out, 8);
        check("stream_in_ready_dropped", longint'(saw_low), 1);
        check("stream_op_count", longint'(op_count), 8);
        check("stream_sb_empty", sb.size(), 0);

        // Reset with two ops in flight
        @(posedge clk); #1;
        in_valid = 1'b1; in_x = 9; in_y = 9; in_mode = 2'b00; in_tag = 4'd5;
        @(posedge clk); #1;
        in_x = 10; in_y = -3; in_tag = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("inflight_rst_out_valid", longint'(out_valid), 0);
        check("inflight_rst_op_count", longint'(op_count), 0);
        @(negedge clk);
        check("inflight_rst_out_valid2", longint'(out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        spurious = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("inflight_no_partial", spurious, 0);
        do_op(2, 2, 2'b01, 4'd3, 4, "post_rst_2x2");
        check("post_rst_op_count", longint'(op_count), 1);

        repeat (3) @(negedge clk);
        check("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
